// File: rtl/fast_corner_pipe.sv
// fast_corner_pipe -- streaming FAST-N corner scorer on a 7x7 window.
//
// One window per accepted transfer; three register stages:
//   S1: 16 bright + 16 dark saturating diffs against the centre, t, mode
//   S2: 16 bright + 16 dark arc minima (one lane per start position)
//   S3: max over arcs, strict compare against t, output fields
// The whole pipe advances on en = !out_valid || out_ready; in_ready = en.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake (window, threshold, mode)
//   window[0:6][0:6]        pixel window, centre at [3][3]
//   threshold               detection threshold t
//   mode                    01 bright, 10 dark, 11 both, 00 off
//   out_valid / out_ready   output handshake
//   is_corner, polarity     result flag, 0 bright / 1 dark
//   score                   max arc score of the winning polarity, else 0
//   frame_start             clears corner_count       (FAST_CORNER_CNT_EN)
//   corner_count            saturating corner counter (FAST_CORNER_CNT_EN)
//
// Optional feature macro: FAST_CORNER_CNT_EN (corner counter + its ports).

// Minimum of FAST_N consecutive diffs starting at START, wrapping mod 16.
module fast_arc_lane #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FAST_N     = 9,
    parameter int unsigned START      = 0
) (
    input  logic [15:0][DATA_WIDTH-1:0] diff,
    output logic [DATA_WIDTH-1:0]       arc_min
);
    logic [3:0] idx;

    always_comb begin
        arc_min = '1;
        idx     = 4'(START);
        for (int k = 0; k < int'(FAST_N); k++) begin
            // 4-bit index wraps naturally around the circle
            idx = 4'(int'(START) + k);
            if (diff[idx] < arc_min) arc_min = diff[idx];
        end
    end
endmodule

module fast_corner_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FAST_N     = 9,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [0:6][0:6][DATA_WIDTH-1:0]     window,
    input  logic [DATA_WIDTH-1:0]               threshold,
    input  logic [1:0]                          mode,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                is_corner,
    output logic                                polarity,
    output logic [DATA_WIDTH-1:0]               score
`ifdef FAST_CORNER_CNT_EN
    ,
    input  logic                                frame_start,
    output logic [CNT_WIDTH-1:0]                corner_count
`endif
);
    localparam int STAGES = 3;

    if ((FAST_N < 9) || (FAST_N > 12)) begin : g_bad_fast_n
        $error("fast_corner_pipe: FAST_N must be in 9..12");
    end

    // Circle coordinates, index 15 down to 0 (index 0 is the LSB entry).
    localparam logic [15:0][2:0] CIRC_R = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6,
                                           3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    localparam logic [15:0][2:0] CIRC_C = {3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                                           3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd5, 3'd4, 3'd3};

    typedef struct packed {
        logic                  is_corner;
        logic                  polarity;
        logic [DATA_WIDTH-1:0] score;
    } res_t;

    logic en;
    logic [STAGES:1] vld_pipe_d, vld_pipe_q;

    logic [15:0][DATA_WIDTH-1:0] db_new, dd_new;
    logic [15:0][DATA_WIDTH-1:0] db_d, db_q, dd_d, dd_q;
    logic [DATA_WIDTH-1:0]       thr1_d, thr1_q;
    logic [1:0]                  mode1_d, mode1_q;

    logic [15:0][DATA_WIDTH-1:0] bmin_new, dmin_new;
    logic [15:0][DATA_WIDTH-1:0] bmin_d, bmin_q, dmin_d, dmin_q;
    logic [DATA_WIDTH-1:0]       thr2_d, thr2_q;
    logic [1:0]                  mode2_d, mode2_q;

    logic [DATA_WIDTH-1:0]       sb, sd;
    logic                        bright, dark;
    res_t                        res_d, res_q;

    // Only the 16 circle pixels and the centre feed the datapath.
    logic unused_window;
    assign unused_window = ^window;

    assign en        = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe_q[STAGES];
    assign is_corner = res_q.is_corner;
    assign polarity  = res_q.polarity;
    assign score     = res_q.score;

    // S1 datapath: saturating diffs
    logic [DATA_WIDTH-1:0] ctr;
    assign ctr = window[3][3];

    for (genvar i = 0; i < 16; i++) begin : g_diff
        logic [DATA_WIDTH-1:0] pix;
        assign pix       = window[CIRC_R[i]][CIRC_C[i]];
        assign db_new[i] = (pix > ctr) ? pix - ctr : '0;
        assign dd_new[i] = (ctr > pix) ? ctr - pix : '0;
    end

    // S2 datapath: one lane per start position and polarity
    for (genvar s = 0; s < 16; s++) begin : g_arc
        fast_arc_lane #(.DATA_WIDTH(DATA_WIDTH), .FAST_N(FAST_N), .START(s)) u_bright (
            .diff    (db_q),
            .arc_min (bmin_new[s])
        );
        fast_arc_lane #(.DATA_WIDTH(DATA_WIDTH), .FAST_N(FAST_N), .START(s)) u_dark (
            .diff    (dd_q),
            .arc_min (dmin_new[s])
        );
    end

    // S3 datapath: best arc per polarity and strict threshold compare
    always_comb begin
        sb = '0;
        sd = '0;
        for (int i = 0; i < 16; i++) begin
            if (bmin_q[i] > sb) sb = bmin_q[i];
            if (dmin_q[i] > sd) sd = dmin_q[i];
        end
        bright = mode2_q[0] && (sb > thr2_q);
        dark   = mode2_q[1] && (sd > thr2_q);
    end

    // Next-state: everything holds when en = 0. Output fields are zeroed for
    // bubbles so a non-valid slot never carries a stale result.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        db_d       = db_q;
        dd_d       = dd_q;
        thr1_d     = thr1_q;
        mode1_d    = mode1_q;
        bmin_d     = bmin_q;
        dmin_d     = dmin_q;
        thr2_d     = thr2_q;
        mode2_d    = mode2_q;
        res_d      = res_q;
        if (en) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
            db_d       = db_new;
            dd_d       = dd_new;
            thr1_d     = threshold;
            mode1_d    = mode;
            bmin_d     = bmin_new;
            dmin_d     = dmin_new;
            thr2_d     = thr1_q;
            mode2_d    = mode1_q;
            res_d      = '0;
            if (vld_pipe_q[2]) begin
                // bright wins if both ever qualify
                res_d.is_corner = bright || dark;
                res_d.polarity  = !bright && dark;
                res_d.score     = bright ? sb : (dark ? sd : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            db_q       <= '0;
            dd_q       <= '0;
            thr1_q     <= '0;
            mode1_q    <= '0;
            bmin_q     <= '0;
            dmin_q     <= '0;
            thr2_q     <= '0;
            mode2_q    <= '0;
            res_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            db_q       <= db_d;
            dd_q       <= dd_d;
            thr1_q     <= thr1_d;
            mode1_q    <= mode1_d;
            bmin_q     <= bmin_d;
            dmin_q     <= dmin_d;
            thr2_q     <= thr2_d;
            mode2_q    <= mode2_d;
            res_q      <= res_d;
        end
    end

`ifdef FAST_CORNER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 cnt_inc;

    assign cnt_inc = vld_pipe_q[STAGES] && out_ready && res_q.is_corner;

    // frame_start restarts the count, still counting a same-cycle corner
    always_comb begin
        cnt_d = cnt_q;
        if (frame_start)
            cnt_d = CNT_WIDTH'(cnt_inc);
        else if (cnt_inc && (cnt_q != '1))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign corner_count = cnt_q;
`else
    if (CNT_WIDTH == 0) begin : g_bad_cnt_width
        $error("fast_corner_pipe: CNT_WIDTH must be non-zero");
    end
`endif

endmodule

// File: tb/tb_fast_corner_pipe.sv
// Bench for fast_corner_pipe: a FAST_N=9 instance and a FAST_N=12 instance
// (small counter, to reach saturation) share all inputs. Each accepted
// window is scored by a direct reference model and queued; results are
// popped and compared at every output handshake.
module tb_fast_corner_pipe;
    localparam int DW = 8;
    typedef logic [0:6][0:6][DW-1:0] win_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, out_ready, frame_start;
    win_t          window;
    logic [DW-1:0] threshold;
    logic [1:0]    mode;

    logic          in_ready9, ov9, cor9, pol9;
    logic [DW-1:0] sc9;
    logic          in_ready12, ov12, cor12, pol12;
    logic [DW-1:0] sc12;
    logic [15:0]   cnt9_o;
    logic [2:0]    cnt12_o;

    fast_corner_pipe #(.DATA_WIDTH(DW), .FAST_N(9), .CNT_WIDTH(16)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready9),
        .window(window), .threshold(threshold), .mode(mode),
        .out_valid(ov9), .out_ready(out_ready), .is_corner(cor9),
        .polarity(pol9), .score(sc9)
`ifdef FAST_CORNER_CNT_EN
        , .frame_start(frame_start), .corner_count(cnt9_o)
`endif
    );

    fast_corner_pipe #(.DATA_WIDTH(DW), .FAST_N(12), .CNT_WIDTH(3)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
        .window(window), .threshold(threshold), .mode(mode),
        .out_valid(ov12), .out_ready(out_ready), .is_corner(cor12),
        .polarity(pol12), .score(sc12)
`ifdef FAST_CORNER_CNT_EN
        , .frame_start(frame_start), .corner_count(cnt12_o)
`endif
    );

`ifndef FAST_CORNER_CNT_EN
    assign cnt9_o  = '0;
    assign cnt12_o = '0;
`endif

    int CR [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
    int CC [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

    typedef struct {
        logic c9, p9;   int s9;
        logic c12, p12; int s12;
        int   acc;      int stl;
    } exp_t;
    exp_t q[$];

    int n_checks = 0, n_err = 0;
    int cyc = 0, stalls = 0, orpat = 0;
    int cnt9_exp = 0, cnt12_exp = 0;
    bit accepted, prev_hold;
    logic h_c9, h_p9; logic [DW-1:0] h_s9, h_s12;
    bit ov_en, ov12_en; logic ov_c, ov_p, ov12_c; int ov_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Straight from the scoring rules: every start, min over the arc, max over starts.
    function automatic void model(input win_t w, input int t, input logic [1:0] m, input int n,
                                  output logic cor, output logic pol, output int sc);
        int c, sb, sd, mb, md, p, b, d, ix;
        c = int'(w[3][3]); sb = 0; sd = 0;
        for (int s = 0; s < 16; s++) begin
            mb = 255; md = 255;
            for (int k = 0; k < n; k++) begin
                ix = (s + k) % 16;
                p  = int'(w[CR[ix]][CC[ix]]);
                b  = (p > c) ? p - c : 0;
                d  = (c > p) ? c - p : 0;
                if (b < mb) mb = b;
                if (d < md) md = d;
            end
            if (mb > sb) sb = mb;
            if (md > sd) sd = md;
        end
        cor = 1'b0; pol = 1'b0; sc = 0;
        if (m[0] && sb > t) begin cor = 1'b1; sc = sb; end
        else if (m[1] && sd > t) begin cor = 1'b1; pol = 1'b1; sc = sd; end
    endfunction

    function automatic win_t mk_win(input int c, input int circ [16]);
        win_t w;
        for (int r = 0; r < 7; r++)
            for (int k = 0; k < 7; k++) w[r][k] = DW'($urandom);
        w[3][3] = DW'(c);
        for (int i = 0; i < 16; i++) w[CR[i]][CC[i]] = DW'(circ[i]);
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        int c, kind, s, len, d, v, ix;
        for (int r = 0; r < 7; r++)
            for (int k = 0; k < 7; k++) w[r][k] = DW'($urandom);
        c    = int'(w[3][3]);
        kind = int'($urandom_range(0, 2));
        if (kind != 0) begin
            s   = int'($urandom_range(0, 15));
            len = int'($urandom_range(7, 14));
            d   = int'($urandom_range(1, 90));
            for (int k = 0; k < len; k++) begin
                ix = (s + k) % 16;
                v  = (kind == 1) ? c + d + int'($urandom_range(0, 15))
                                 : c - d - int'($urandom_range(0, 15));
                if (v > 255) v = 255;
                if (v < 0)   v = 0;
                w[CR[ix]][CC[ix]] = DW'(v);
            end
        end
        return w;
    endfunction

    // One clock: called just after a negedge with inputs applied.
    task automatic cycle();
        exp_t e;
        bit inc9, inc12;
        case (orpat)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (prev_hold) begin
            chk("hold_valid", ov9, 1);
            chk("hold_corner", cor9, h_c9);
            chk("hold_pol", pol9, h_p9);
            chk("hold_score", sc9, h_s9);
            chk("hold_score12", sc12, h_s12);
        end
        chk("in_ready", in_ready9, !ov9 || out_ready);
        chk("valid12", ov12, ov9);
        accepted = 0; inc9 = 0; inc12 = 0;
        if (ov9 && out_ready) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = q.pop_front();
                chk("corner9", cor9, e.c9);
                chk("pol9", pol9, e.p9);
                chk("score9", sc9, e.s9);
                chk("corner12", cor12, e.c12);
                chk("pol12", pol12, e.p12);
                chk("score12", sc12, e.s12);
                chk("latency", cyc - e.acc, 3 + stalls - e.stl);
                inc9 = e.c9; inc12 = e.c12;
            end
        end
        if (in_valid && in_ready9) begin
            model(window, int'(threshold), mode, 9, e.c9, e.p9, e.s9);
            model(window, int'(threshold), mode, 12, e.c12, e.p12, e.s12);
            if (ov_en)   begin e.c9 = ov_c; e.p9 = ov_p; e.s9 = ov_s; ov_en = 0; end
            if (ov12_en) begin e.c12 = ov12_c; e.p12 = 1'b0; e.s12 = 0; ov12_en = 0; end
            e.acc = cyc; e.stl = stalls;
            q.push_back(e);
            accepted = 1;
        end
        prev_hold = ov9 && !out_ready;
        h_c9 = cor9; h_p9 = pol9; h_s9 = sc9; h_s12 = sc12;
        if (!in_ready9) stalls++;
        if (frame_start) begin cnt9_exp = int'(inc9); cnt12_exp = int'(inc12); end
        else begin
            if (inc9 && cnt9_exp != 65535) cnt9_exp++;
            if (inc12 && cnt12_exp != 7)   cnt12_exp++;
        end
        cyc++;
        @(negedge clk);
`ifdef FAST_CORNER_CNT_EN
        chk("count9", cnt9_o, cnt9_exp);
        chk("count12", cnt12_o, cnt12_exp);
`endif
    endtask

    task automatic send(input win_t w, input int t, input logic [1:0] m);
        in_valid = 1'b1; window = w; threshold = DW'(t); mode = m;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic dir(input int c, input int circ [16], input int t, input logic [1:0] m,
                       input logic ec, input logic ep, input int es,
                       input bit e12_en, input logic e12c);
        ov_en = 1; ov_c = ec; ov_p = ep; ov_s = es;
        ov12_en = e12_en; ov12_c = e12c;
        send(mk_win(c, circ), t, m);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && !ov9) break;
            cycle();
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", ov9, 0);
        chk("rst_out_valid12", ov12, 0);
        chk("rst_in_ready", in_ready9, 1);
        chk("rst_corner", cor9, 0);
        chk("rst_pol", pol9, 0);
        chk("rst_score", sc9, 0);
`ifdef FAST_CORNER_CNT_EN
        chk("rst_count", cnt9_o, 0);
`endif
        q.delete();
        prev_hold = 0; cnt9_exp = 0; cnt12_exp = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc [16] = '{140, 135, 130, 150, 145, 140, 135, 130, 121, 130, 135, 140, 145, 150, 135, 130};
        int dk [16];
        int eq [16];
        int wr [16];
        for (int i = 0; i < 16; i++) begin
            dk[i] = 150;
            eq[i] = 120;
            wr[i] = (i >= 12 || i <= 4) ? 160 : 100;
        end
        in_valid = 0; out_ready = 1; frame_start = 0;
        window = '0; threshold = '0; mode = '0;
        do_reset();

        // directed cases
        orpat = 0;
        dir(100, bc, 20, 2'b11, 1, 0, 30, 0, 0);
        dir(200, dk, 20, 2'b11, 1, 1, 50, 0, 0);
        dir(200, dk, 20, 2'b01, 0, 0, 0, 0, 0);
        dir(100, eq, 20, 2'b11, 0, 0, 0, 0, 0);
        dir(100, eq, 19, 2'b11, 1, 0, 20, 0, 0);
        dir(100, wr, 20, 2'b11, 1, 0, 60, 1, 0);
        dir(100, bc, 20, 2'b00, 0, 0, 0, 1, 0);
        drain();

        // backpressure: ready pattern 1,0,0,...
        orpat = 1;
        for (int i = 0; i < 6; i++)
            send(rand_win(), int'($urandom_range(0, 60)), 2'b11);
        drain();

        // random traffic with a reset in the middle
        orpat = 2;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            send(rand_win(), int'($urandom_range(0, 70)), 2'($urandom_range(0, 3)));
        end
        drain();

`ifdef FAST_CORNER_CNT_EN
        orpat = 0;
        frame_start = 1; cycle(); frame_start = 0;
        for (int i = 0; i < 7; i++)
            send(mk_win(200, dk), 20, (i == 2 || i == 5) ? 2'b00 : 2'b11);
        drain();
        chk("count_five", cnt9_o, 5);
        chk("count_five12", cnt12_o, 5);
        send(mk_win(200, dk), 20, 2'b11);
        for (int i = 0; i < 20; i++) begin
            frame_start = ov9;
            cycle();
            if (frame_start) break;
        end
        frame_start = 0;
        chk("count_fs_inc", cnt9_o, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
